ram_rd_check: RTL
=================

Name: ram_rd_check

Overview:
Read-side checker for the on-chip single-port block RAM. Once a writer has filled the RAM, a start pulse makes this block sweep every address, fetch each word with the RAM's fixed read latency, and compare it with the writer's known pattern. It streams out the read data and reports pass/fail, error count and first failing address. It sits beside the RAM write controller in the ip_ram top and shares the RAM port with it through an external mux.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 8, RAM data width
DEPTH, 32, number of words swept; 1..2^ADDR_W
RD_LAT, 1, RAM read latency in clocks; 1..4
PAT_OFFSET, 0, expected word = (addr + PAT_OFFSET) truncated to DATA_W

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a sweep; honoured only in IDLE
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable; constant 0
ram_addr  out  ADDR_W  RAM read address
ram_rd_data  in  DATA_W  RAM read data
busy  out  1  sweep in progress
rd_valid  out  1  rd_data/rd_addr valid this cycle
rd_data  out  DATA_W  word read back
rd_addr  out  ADDR_W  address of rd_data
done  out  1  one-cycle pulse at end of sweep
err  out  1  sticky mismatch flag for the current/last sweep
err_cnt  out  ADDR_W+1  mismatch count, saturating at all-ones
first_err_addr  out  ADDR_W  address of first mismatch; 0 if none

Behaviour:
- Reset is synchronous and active-high. All outputs go to 0 on the edge where sys_rst is sampled high, and the FSM goes to IDLE. This holds mid-sweep: ram_en drops the cycle after, and in-flight pipeline entries are discarded.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: on start=1 at edge E0, go to READ. Set busy=1, ram_en=1, ram_addr=0. On the same edge clear err, err_cnt and first_err_addr.
- READ: address k is presented in the cycle after edge Ek. Addresses increment by 1 from 0 to DEPTH-1, with no wrap inside a sweep. When address DEPTH-1 has been presented, the next edge sets ram_en=0, resets ram_addr to 0 and moves to DRAIN.
- The read pipeline is a shift register of RD_LAT stages carrying (valid, addr). At edge E(k+RD_LAT), ram_rd_data is sampled and registered into rd_data, with rd_addr=k and rd_valid=1 for one cycle.
- Comparison is made on the same edge against (k+PAT_OFFSET) mod 2^DATA_W. On a mismatch:
  - err is set.
  - err_cnt increments, saturating.
  - If this is the first mismatch of the sweep, first_err_addr is set to k.
- DRAIN: wait until the pipeline is empty. The last rd_valid is in the cycle after edge E(DEPTH-1+RD_LAT). The next edge goes to DONE with done=1 and busy=0, so done is high in the cycle after edge E(DEPTH+RD_LAT).
- DONE: lasts one cycle, then returns to IDLE. err, err_cnt and first_err_addr hold until the next accepted start or reset.
- start is ignored while busy or in DONE. A start in the cycle after done (i.e. in IDLE) is accepted.
- ram_en is never high outside READ. ram_we is always 0.
- Every handshake output is a registered output.

Test Plan:
1. Defaults, RAM preloaded with word[a]=a, start at E0 -> rd_valid for 32 consecutive cycles after E1..E32 with rd_data 0..31; done high after E33; err=0, err_cnt=0, first_err_addr=0.
2. RAM word[7]=8'hFF, others correct -> single rd_valid cycle with rd_addr=7, rd_data=FF; err=1, err_cnt=1, first_err_addr=7 at done.
3. Corrupt addresses 3 and 20 -> err_cnt=2, first_err_addr=3. A second start with a clean RAM -> err=0, err_cnt=0 after the start edge and at done.
4. RD_LAT=2 RAM model -> first rd_valid after E2, last after E33, done after E34; data 0..31 with no errors.
5. start pulsed again at E10 mid-sweep and during the done cycle -> both ignored; exactly 32 rd_valid cycles and one done pulse.
6. sys_rst high at the edge where ram_addr=10 -> next cycle all outputs 0 and no further rd_valid. A new start then restarts the sweep from address 0 and completes with err=0.

Source files
------------

// File: rtl/ram_rd_check.sv
// Read-side checker for the single-port block RAM: sweeps every address after a
// start pulse, streams the words out and compares them with the writer's pattern.
module ram_rd_check #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 32,
   parameter int RD_LAT     = 1,
   parameter int PAT_OFFSET = 0
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              start,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              busy,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);

   // state   | meaning
   // IDLE    | waiting for start
   // READ    | presenting addresses 0..DEPTH-1
   // DRAIN   | waiting for in-flight reads to return
   // DONE    | one-cycle done pulse, results held
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [DATA_W-1:0] PAT_OFS_W = DATA_W'(PAT_OFFSET);

   logic [1:0]        r_state;
   logic              r_ram_en;
   logic [ADDR_W-1:0] r_ram_addr;
   logic              r_busy;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rd_data;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_done;
   logic              r_err;
   logic [ADDR_W:0]   r_err_cnt;
   logic [ADDR_W-1:0] r_first_err_addr;

   logic              w_tap_vld;
   logic [ADDR_W-1:0] w_tap_addr;
   logic              w_pipe_busy;
   logic [DATA_W-1:0] w_exp;
   logic              w_mis;

   // The tap is the (valid, addr) pair whose data is on ram_rd_data this cycle.
   generate
      if (RD_LAT == 1) begin : g_lat1
         assign w_tap_vld   = r_ram_en;
         assign w_tap_addr  = r_ram_addr;
         assign w_pipe_busy = r_ram_en;
      end else begin : g_latn
         logic [RD_LAT-2:0] r_pv;
         logic [ADDR_W-1:0] r_pa [RD_LAT-1];

         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               r_pv <= '0;
               for (int i = 0; i < RD_LAT - 1; i++) r_pa[i] <= '0;
            end else begin
               r_pv[0] <= r_ram_en;
               r_pa[0] <= r_ram_addr;
               for (int i = 1; i < RD_LAT - 1; i++) begin
                  r_pv[i] <= r_pv[i-1];
                  r_pa[i] <= r_pa[i-1];
               end
            end
         end

         assign w_tap_vld   = r_pv[RD_LAT-2];
         assign w_tap_addr  = r_pa[RD_LAT-2];
         assign w_pipe_busy = r_ram_en | (|r_pv);
      end
   endgenerate

   assign w_exp = DATA_W'(w_tap_addr) + PAT_OFS_W;
   assign w_mis = w_tap_vld && (ram_rd_data != w_exp);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state          <= S_IDLE;
         r_ram_en         <= 1'b0;
         r_ram_addr       <= '0;
         r_busy           <= 1'b0;
         r_rd_valid       <= 1'b0;
         r_rd_data        <= '0;
         r_rd_addr        <= '0;
         r_done           <= 1'b0;
         r_err            <= 1'b0;
         r_err_cnt        <= '0;
         r_first_err_addr <= '0;
      end else begin
         r_rd_valid <= w_tap_vld;
         r_done     <= 1'b0;
         if (w_tap_vld) begin
            r_rd_data <= ram_rd_data;
            r_rd_addr <= w_tap_addr;
         end
         if (w_mis) begin
            r_err <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + (ADDR_W+1)'(1);
            if (!r_err) r_first_err_addr <= w_tap_addr;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state          <= S_READ;
                  r_ram_en         <= 1'b1;
                  r_ram_addr       <= '0;
                  r_busy           <= 1'b1;
                  r_err            <= 1'b0;
                  r_err_cnt        <= '0;
                  r_first_err_addr <= '0;
               end
            end
            S_READ: begin
               if (r_ram_addr == LAST_ADDR) begin
                  r_ram_en   <= 1'b0;
                  r_ram_addr <= '0;
                  r_state    <= S_DRAIN;
               end else begin
                  r_ram_addr <= r_ram_addr + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               if (!w_pipe_busy) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ram_en         = r_ram_en;
   assign ram_we         = 1'b0;
   assign ram_addr       = r_ram_addr;
   assign busy           = r_busy;
   assign rd_valid       = r_rd_valid;
   assign rd_data        = r_rd_data;
   assign rd_addr        = r_rd_addr;
   assign done           = r_done;
   assign err            = r_err;
   assign err_cnt        = r_err_cnt;
   assign first_err_addr = r_first_err_addr;

endmodule
